md_sequencer: RTL and testbench
===============================

# md_sequencer

Sequencer for the multiply/divide unit and its HI/LO register pair in the 5-stage MIPS pipeline. The block is driven from the E stage by the decoded start / MD-operation fields. It captures the operands and runs a per-operation latency counter, commits results to HI/LO, and produces the stall that holds MD-class instructions in D while the unit is occupied. An exception request in the same cycle suppresses the launch.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu (and madd when enabled); legal range 1–15.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range 1–15.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: E-stage launch of mult/multu/div/divu (or madd).
- `md_op` input 3: operation code.
  - 000 none / mfhi / mflo
  - 001 mult
  - 010 multu
  - 011 div
  - 100 divu
  - 101 mthi
  - 110 mtlo
  - 111 madd
- `a`, `b` input 32 each: E-stage rs/rt values after forwarding.
- `exc_req` input 1: exception/interrupt taken this cycle; cancels any E-stage launch or write.
- `md_use_d` input 1: instruction in D is MD-class (mult/div/mthi/mtlo/mfhi/mflo).
- `hi`, `lo` output 32 each: architectural HI/LO, registered.
- `busy` output 1: operation in flight, registered.
- `md_stall` output 1: combinational stall request to the hazard unit.

## Operation
- States: IDLE (`cnt` = 0) and RUN (`cnt` ≠ 0). `busy` = (`cnt` ≠ 0).
- **Launch condition:** `start` & !`exc_req` & !`busy` & `md_op` ∈ {001, 010, 011, 100, 111*}.
  - On launch, capture `a`, `b`, and `md_op`.
  - Load `cnt` with `MULT_CYCLES` (001/010/111) or `DIV_CYCLES` (011/100).
  - (*111 only when `MD_MADD_EN` is defined.)
- **RUN:** `cnt` decrements each cycle. On the edge where `cnt` = 1, HI/LO take the result computed from the captured operands, and `cnt` goes to 0.
- **Results:**
  - mult: signed 64-bit product; {HI,LO} = a × b.
  - multu: unsigned 64-bit product; {HI,LO} = a × b.
  - div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: HI = captured `a`, LO = 32'hFFFF_FFFF (both signed and unsigned).
  - Signed 0x8000_0000 / −1: LO = 0x8000_0000, HI = 0.
- **mthi/mtlo:** when `md_op` = 101/110 and !`exc_req`, HI or LO = `a` at the next edge, independent of `start`. No busy period.
  - If asserted while `busy` (illegal; prevented by the stall), the write occurs, and the later commit overwrites both HI and LO.
- `start` while `busy`: ignored; no recapture, counter undisturbed.
- `exc_req` while `busy`: no effect; the in-flight operation completes and commits.
- `md_stall` = `md_use_d` & (`busy` | launch condition).
- Undefined `md_op` values with `start`: no launch, no state change.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `cnt` = 0, captured operands = 0, `md_stall` = `md_use_d` & launch condition.
- Assertion of `rst_n` low mid-operation clears everything immediately. No commit occurs after release.
- Launch edge at the end of cycle t: `busy` is high in cycles t+1 … t+N (N = `MULT_CYCLES` or `DIV_CYCLES`).
- Result is visible on `hi`/`lo` in cycle t+N+1, together with `busy` = 0.
- mfhi/mflo held in D is released in cycle t+N+1 and reads the new HI/LO that cycle.
- Back-to-back: a new launch is accepted in cycle t+N+1. That is the earliest possible, because `md_stall` holds the follow-on instruction.
- mthi/mtlo: single-edge update, visible the next cycle.

## Configuration
- `MD_MADD_EN` defined: `md_op` 111 with `start` launches madd.
  - Operation: {HI,LO} = {HI,LO} + signed(a × b), mod 2^64.
  - HI/LO used in the sum are sampled at commit.
  - Latency is `MULT_CYCLES`.
- Not defined: `md_op` 111 is an undefined op and is ignored. No launch, no stall contribution beyond `md_use_d` & `busy`.

## Structure
- Shared package `md_pkg` holds:
  - `md_op` encodings (`MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`, `MD_MADD`), shared with the main controller's MDControl output.
  - Default latency constants.
- Sub-module `md_calc`: combinational 64-bit result from captured op/a/b (and HI/LO for madd), including the divide-by-zero and overflow cases. The sequencer owns the counter, capture registers, HI/LO, and stall.

## Test plan
- **mult:** `start`, `md_op` = 001, `a` = 0xFFFF_FFFD, `b` = 5.
  - `busy` is high for 5 cycles.
  - Then HI = 0xFFFF_FFFF, LO = 0xFFFF_FFF1.
  - With `md_use_d` = 1 throughout, `md_stall` is high from the launch cycle through the last busy cycle.
- **divu:** 100 / 7 gives LO = 14, HI = 2 after 10 busy cycles.
- **Signed div and divide by zero:**
  - div −7 / 2 gives LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
  - div 0x1234 / 0 gives HI = 0x1234, LO = 0xFFFF_FFFF.
- **Exception:**
  - `start` with `exc_req` = 1 in the same cycle gives `busy` = 0 and HI/LO unchanged.
  - `exc_req` in the 2nd busy cycle of a mult: the result still commits on schedule.
- **mthi/mtlo and reset:**
  - mthi `a` = 0xDEAD_BEEF gives HI = 0xDEAD_BEEF next cycle, LO unchanged.
  - `rst_n` pulse in the 4th cycle of a div gives HI = LO = 0 and `busy` = 0, with no later commit.
- **madd (`MD_MADD_EN`):** HI = 0, LO = 0xFFFF_FFFF, then madd 1 × 1 gives HI = 1, LO = 0. Without the macro, the same stimulus leaves HI/LO unchanged and `busy` = 0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared MD-unit encodings and latency defaults for the sequencer and the main controller.
// Optional madd support is selected by defining MD_MADD_EN.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_MADD  = 3'b111
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  // Ops that occupy the unit for a latency period.
  function automatic logic is_launch_op(input logic [2:0] op);
    case (md_op_e'(op))
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
      MD_MADD:                            return MADD_EN;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit {HI,LO} result from the captured operation and operands,
// including divide-by-zero and signed-overflow cases.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic               div_ovf;

  assign sprod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod   = {32'd0, a} * {32'd0, b};
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    res = 64'd0;
    case (md_op_e'(op))
      MD_MULT:  res = $unsigned(sprod);
      MD_MULTU: res = uprod;
      MD_DIV: begin
        // SV signed / and % truncate toward zero; remainder follows the dividend.
        if (b == 32'd0)   res = {a, 32'hFFFF_FFFF};
        else if (div_ovf) res = {32'd0, 32'h8000_0000};
        else              res = {$unsigned($signed(a) % $signed(b)),
                                 $unsigned($signed(a) / $signed(b))};
      end
      MD_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      MD_MADD:  res = {hi, lo} + $unsigned(sprod);
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: operand capture, latency counter, HI/LO commit and D-stage stall.
// Defining MD_MADD_EN enables the madd operation (md_op 111).
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        exc_req,
  input  logic        md_use_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  logic [3:0]  cnt;
  logic [2:0]  cap_op;
  logic [31:0] cap_a, cap_b;
  logic [63:0] res;
  logic        launch;

  assign launch   = start & ~exc_req & ~busy & is_launch_op(md_op);
  assign md_stall = md_use_d & (busy | launch);

  md_calc u_calc (
    .op  (cap_op),
    .a   (cap_a),
    .b   (cap_b),
    .hi  (hi),
    .lo  (lo),
    .res (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 4'd0;
      busy   <= 1'b0;
      cap_op <= 3'd0;
      cap_a  <= 32'd0;
      cap_b  <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      if (!exc_req && md_op == MD_MTHI) hi <= a;
      if (!exc_req && md_op == MD_MTLO) lo <= a;
      // Commit is written after mthi/mtlo so it wins if both land on one edge.
      if (launch) begin
        cap_op <= md_op;
        cap_a  <= a;
        cap_b  <= b;
        cnt    <= is_div_op(md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        busy   <= 1'b1;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          {hi, lo} <= res;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: stimulus pushes expected {HI,LO} commits,
// a negedge monitor pops and compares on each busy falling edge.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        exc_req = 1'b0;
  logic        md_use_d = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, md_stall;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model;
  logic        prev_busy = 1'b0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .a(a), .b(b),
    .exc_req(exc_req), .md_use_d(md_use_d), .hi(hi), .lo(lo),
    .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: a commit is a busy 1->0 transition outside reset.
  always @(negedge clk) begin
    if (rst_n && prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_commit actual=%h expected=none", {hi, lo});
      end else begin
        chk("commit_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
    prev_busy = busy && rst_n;
  end

  // Launch in the current cycle, then count busy cycles and watch the stall.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] aa,
                        input logic [31:0] bb, input int n, input logic [63:0] exp,
                        input bit disturb);
    int cyc, bad_stall;
    md_use_d = 1'b1; start = 1'b1; md_op = op; a = aa; b = bb;
    #1;
    chk({nm, "_launch_stall"}, md_stall, 1);
    chk({nm, "_idle_before"}, busy, 0);
    exp_q.push_back(exp);
    model = exp;
    tick();
    start = 1'b0; md_op = MD_NONE; a = 32'd0; b = 32'd0;
    cyc = 0; bad_stall = 0;
    while (busy && cyc < 40) begin
      exc_req = disturb && (cyc == 1);
      start   = disturb && (cyc == 2);
      md_op   = (disturb && cyc == 2) ? MD_DIVU : MD_NONE;
      a       = (disturb && cyc == 2) ? 32'd99 : 32'd0;
      b       = (disturb && cyc == 2) ? 32'd3 : 32'd0;
      #1;
      if (md_stall !== 1'b1) bad_stall++;
      cyc++;
      @(posedge clk); #1;
    end
    exc_req = 1'b0; start = 1'b0; md_op = MD_NONE; a = 32'd0; b = 32'd0;
    chk({nm, "_busy_cycles"}, 64'(cyc), 64'(n));
    chk({nm, "_stall_while_busy"}, 64'(bad_stall), 0);
    chk({nm, "_result_visible"}, {hi, lo}, exp);
    md_use_d = 1'b0;
  endtask

  initial begin
    // Reset state; stall still reflects a launch request during reset.
    md_use_d = 1'b1; start = 1'b1; md_op = MD_MULT;
    #2;
    chk("reset_stall", md_stall, 1);
    chk("reset_hilo", {hi, lo}, 0);
    chk("reset_busy", busy, 0);
    start = 1'b0; md_op = MD_NONE; md_use_d = 1'b0;
    #1;
    chk("reset_stall_idle", md_stall, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    model = 64'd0;

    run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, {32'd2, 32'd14}, 0);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_op("div_zero", MD_DIV, 32'h1234, 32'd0, 10, {32'h1234, 32'hFFFF_FFFF}, 0);
    run_op("divu_zero", MD_DIVU, 32'd5, 32'd0, 10, {32'd5, 32'hFFFF_FFFF}, 0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, {32'd0, 32'h8000_0000}, 0);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001, 0);
    // Exception in 2nd busy cycle plus a start while busy: original op still commits.
    run_op("mult_exc", MD_MULT, 32'd7, 32'd6, 5, 64'd42, 1);

    // Exception in the launch cycle cancels the launch.
    md_use_d = 1'b1; start = 1'b1; md_op = MD_MULT; a = 32'd3; b = 32'd3; exc_req = 1'b1;
    #1;
    chk("exc_launch_stall", md_stall, 0);
    tick();
    start = 1'b0; md_op = MD_NONE; exc_req = 1'b0; md_use_d = 1'b0;
    chk("exc_launch_busy", busy, 0);
    chk("exc_launch_hilo", {hi, lo}, model);

    // mthi / mtlo, and mthi suppressed by exception.
    md_op = MD_MTHI; a = 32'hDEAD_BEEF;
    tick();
    md_op = MD_NONE;
    model[63:32] = 32'hDEAD_BEEF;
    chk("mthi", {hi, lo}, model);
    chk("mthi_busy", busy, 0);
    md_op = MD_MTLO; a = 32'h0BAD_F00D;
    tick();
    md_op = MD_NONE;
    model[31:0] = 32'h0BAD_F00D;
    chk("mtlo", {hi, lo}, model);
    md_op = MD_MTHI; a = 32'h1111_1111; exc_req = 1'b1;
    tick();
    md_op = MD_NONE; exc_req = 1'b0;
    chk("mthi_exc", {hi, lo}, model);

    // madd: HI=0, LO=FFFFFFFF then 1x1.
    md_op = MD_MTHI; a = 32'd0; tick();
    md_op = MD_MTLO; a = 32'hFFFF_FFFF; tick();
    md_op = MD_NONE; a = 32'd0;
    model = {32'd0, 32'hFFFF_FFFF};
    chk("madd_setup", {hi, lo}, model);
`ifdef MD_MADD_EN
    run_op("madd", MD_MADD, 32'd1, 32'd1, 5, {32'd1, 32'd0}, 0);
`else
    md_use_d = 1'b1; start = 1'b1; md_op = MD_MADD; a = 32'd1; b = 32'd1;
    #1;
    chk("madd_off_stall", md_stall, 0);
    tick();
    start = 1'b0; md_op = MD_NONE; a = 32'd0; b = 32'd0; md_use_d = 1'b0;
    chk("madd_off_busy", busy, 0);
    repeat (6) tick();
    chk("madd_off_hilo", {hi, lo}, model);
`endif

    // Reset pulse in the 4th busy cycle of a div: everything clears, no commit later.
    start = 1'b1; md_op = MD_DIV; a = 32'd50; b = 32'd5;
    tick();
    start = 1'b0; md_op = MD_NONE; a = 32'd0; b = 32'd0;
    tick(); tick(); tick();
    chk("div_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hilo", {hi, lo}, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (14) tick();
    chk("rst_no_commit_hilo", {hi, lo}, 0);
    chk("rst_no_commit_busy", busy, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
